morse_stream_decoder: RTL and testbench

//  Parametrised Morse decoder for one debounced key input: classifies marks as dot/dash by duration and gaps as symbol/letter/word breaks.

---
 rtl/morse_pkg.sv | 63 ++++++
 rtl/morse_debouncer.sv | 38 +++
 rtl/morse_stream_decoder.sv | 130 +++++++++++++
 tb/tb_morse_stream_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types, ASCII constants and the Morse code table for the stream decoder.
// Codes hold the first symbol in the MSB of the len used bits; dash=1, dot=0.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP,
    WGAP
  } state_t;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  function automatic logic [7:0] morse_lookup(
    input logic [4:0] code,
    input logic [2:0] len
  );
    logic [7:0] ch;
    ch = ASCII_UNKNOWN;
    case ({len, code})
      {3'd2, 5'b00001}: ch = 8'h41;
      {3'd4, 5'b01000}: ch = 8'h42;
      {3'd4, 5'b01010}: ch = 8'h43;
      {3'd3, 5'b00100}: ch = 8'h44;
      {3'd1, 5'b00000}: ch = 8'h45;
      {3'd4, 5'b00010}: ch = 8'h46;
      {3'd3, 5'b00110}: ch = 8'h47;
      {3'd4, 5'b00000}: ch = 8'h48;
      {3'd2, 5'b00000}: ch = 8'h49;
      {3'd4, 5'b00111}: ch = 8'h4A;
      {3'd3, 5'b00101}: ch = 8'h4B;
      {3'd4, 5'b00100}: ch = 8'h4C;
      {3'd2, 5'b00011}: ch = 8'h4D;
      {3'd2, 5'b00010}: ch = 8'h4E;
      {3'd3, 5'b00111}: ch = 8'h4F;
      {3'd4, 5'b00110}: ch = 8'h50;
      {3'd4, 5'b01101}: ch = 8'h51;
      {3'd3, 5'b00010}: ch = 8'h52;
      {3'd3, 5'b00000}: ch = 8'h53;
      {3'd1, 5'b00001}: ch = 8'h54;
      {3'd3, 5'b00001}: ch = 8'h55;
      {3'd4, 5'b00001}: ch = 8'h56;
      {3'd3, 5'b00011}: ch = 8'h57;
      {3'd4, 5'b01001}: ch = 8'h58;
      {3'd4, 5'b01011}: ch = 8'h59;
      {3'd4, 5'b01100}: ch = 8'h5A;
      {3'd5, 5'b11111}: ch = 8'h30;
      {3'd5, 5'b01111}: ch = 8'h31;
      {3'd5, 5'b00111}: ch = 8'h32;
      {3'd5, 5'b00011}: ch = 8'h33;
      {3'd5, 5'b00001}: ch = 8'h34;
      {3'd5, 5'b00000}: ch = 8'h35;
      {3'd5, 5'b10000}: ch = 8'h36;
      {3'd5, 5'b11000}: ch = 8'h37;
      {3'd5, 5'b11100}: ch = 8'h38;
      {3'd5, 5'b11110}: ch = 8'h39;
      default:          ch = ASCII_UNKNOWN;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/morse_debouncer.sv
// Two-flop synchroniser plus stability counter for the raw Morse key.
// key_db follows the synchronised key once it has differed for DEBOUNCE_CYCLES.
module morse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s0;
  logic          s1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0     <= 1'b0;
      s1     <= 1'b0;
      key_db <= 1'b0;
      cnt    <= '0;
    end else begin
      s0 <= key;
      s1 <= s0;
      if (s1 == key_db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        key_db <= s1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse key decoder: debounced key -> dot/dash/gap timing -> one ASCII byte per letter.
// Define MORSE_WORD_SPACE_EN to emit an ASCII space after a word-length silence.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 12_500_000,
  parameter int DEBOUNCE_CYCLES  = 1_250_000,
  parameter int DASH_UNITS       = 2,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7,
  parameter int MAX_SYMBOLS      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       error,
  output logic       busy,
  output logic [2:0] sym_count
);

  localparam int PW = $clog2(UNIT_CYCLES + 1);
  localparam int UW = $clog2(WORD_GAP_UNITS + 1);

  state_t        state;
  logic          key_db;
  logic          key_q;
  logic [PW-1:0] pcnt;
  logic [UW-1:0] units;
  logic [4:0]    code;
  logic          ovf;
  logic [7:0]    lk;

  morse_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .key_db(key_db)
  );

  wire rise  = key_db & ~key_q;
  wire fall  = ~key_db & key_q;
  wire kedge = rise | fall;
  wire tick  = pcnt == PW'(UNIT_CYCLES - 1);
  wire dash  = units >= UW'(DASH_UNITS);
  wire lgap  = tick && units == UW'(LETTER_GAP_UNITS - 1);
  wire full  = sym_count == 3'(MAX_SYMBOLS);
`ifdef MORSE_WORD_SPACE_EN
  wire wgap  = tick && units == UW'(WORD_GAP_UNITS - 1);
  localparam state_t AFTER = WGAP;
`else
  localparam state_t AFTER = IDLE;
`endif

  assign lk   = morse_lookup(code, sym_count);
  assign busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      key_q        <= 1'b0;
      pcnt         <= '0;
      units        <= '0;
      code         <= '0;
      ovf          <= 1'b0;
      sym_count    <= '0;
      letter       <= 8'h00;
      letter_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      key_q        <= key_db;
      letter_valid <= 1'b0;
      if (kedge) begin
        pcnt  <= '0;
        units <= '0;
      end else if (tick) begin
        pcnt <= '0;
        if (units != UW'(WORD_GAP_UNITS))
          units <= units + UW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
      unique case (state)
        IDLE: if (rise) state <= MARK;
        MARK: begin
          if (fall) begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              code      <= {code[3:0], dash};
              sym_count <= sym_count + 3'd1;
            end
            state <= GAP;
          end
        end
        GAP: begin
          // a rise landing on the closing tick still ends the letter
          if (lgap) begin
            letter       <= ovf ? ASCII_UNKNOWN : lk;
            error        <= ovf | (lk == ASCII_UNKNOWN);
            letter_valid <= 1'b1;
            code         <= '0;
            sym_count    <= '0;
            ovf          <= 1'b0;
            state        <= rise ? MARK : AFTER;
          end else if (rise) begin
            state <= MARK;
          end
        end
`ifdef MORSE_WORD_SPACE_EN
        WGAP: begin
          if (wgap) begin
            letter       <= ASCII_SPACE;
            error        <= 1'b0;
            letter_valid <= 1'b1;
            state        <= rise ? MARK : IDLE;
          end else if (rise) begin
            state <= MARK;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Scoreboard bench for morse_stream_decoder: random letters against a string-keyed Morse table.
// Honours MORSE_WORD_SPACE_EN when deciding whether a word gap yields a space.
module tb_morse_stream_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic [7:0] letter;
  logic       letter_valid;
  logic       error;
  logic       busy;
  logic [2:0] sym_count;

  morse_stream_decoder #(
    .UNIT_CYCLES     (4),
    .DEBOUNCE_CYCLES (2),
    .DASH_UNITS      (2),
    .LETTER_GAP_UNITS(3),
    .WORD_GAP_UNITS  (7),
    .MAX_SYMBOLS     (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .letter      (letter),
    .letter_valid(letter_valid),
    .error       (error),
    .busy        (busy),
    .sym_count   (sym_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ch;
    logic       err;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] tbl[string];
  string      codes[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....",
    "-....", "--...", "---..", "----."
  };
  string      alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    key = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_letter(input string p);
    if (p.len() <= 5 && tbl.exists(p))
      q.push_back('{tbl[p], 1'b0});
    else
      q.push_back('{8'h3F, 1'b1});
  endtask

  task automatic exp_space();
`ifdef MORSE_WORD_SPACE_EN
    q.push_back('{8'h20, 1'b0});
`endif
  endtask

  task automatic send(input string p, input int gap);
    int d;
    for (int i = 0; i < p.len(); i++) begin
      d = (p[i] == "-") ? int'($urandom_range(10, 20))
                        : int'($urandom_range(3, 7));
      hold(1'b1, d);
      d = (i == p.len() - 1) ? gap : int'($urandom_range(3, 8));
      hold(1'b0, d);
    end
  endtask

  function automatic string rand_pattern();
    string s;
    int    n;
    if ($urandom_range(0, 4) != 0) return codes[$urandom_range(0, 35)];
    s = "";
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) s = $urandom_range(0, 1) ? {s, "-"} : {s, "."};
    return s;
  endfunction

  // monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && letter_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got letter %0h, expected none", letter);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("letter", {24'd0, letter}, {24'd0, e.ch});
        chk("error", {31'd0, error}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string p;
    for (int i = 0; i < 36; i++) tbl[codes[i]] = alpha[i];
    reset = 1'b1;
    key   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_letter", {24'd0, letter}, 32'h00);
    chk("rst_valid", {31'd0, letter_valid}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_symcnt", {29'd0, sym_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold(1'b0, 5);

    exp_letter(".-");
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 12);
    exp_space();
    hold(1'b0, 40);
    chk("a_busy_after", {31'd0, busy}, 32'd0);

    exp_letter("...");
    exp_space();
    send("...", 40);
    exp_letter("-----");
    exp_space();
    send("-----", 40);
    exp_letter("-");
    exp_space();
    send("-", 40);

    exp_letter("......");
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 4);
      hold(1'b0, (i == 5) ? 6 : 4);
    end
    chk("ovf_symcnt", {29'd0, sym_count}, 32'd5);
    exp_space();
    hold(1'b0, 40);

    hold(1'b1, 1);
    hold(1'b0, 20);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_symcnt", {29'd0, sym_count}, 32'd0);

    exp_letter(".");
    exp_space();
    send(".", 40);
    chk("e_busy_after", {31'd0, busy}, 32'd0);

    chk("pre_reset_queue", q.size(), 32'd0);
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 8);
    reset = 1'b1;
    hold(1'b1, 3);
    hold(1'b0, 6);
    reset = 1'b0;
    hold(1'b0, 20);
    chk("rst_mid_letter", {24'd0, letter}, 32'h00);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    exp_letter(".");
    exp_space();
    send(".", 40);

    hold(1'b1, 200);
    chk("held_busy", {31'd0, busy}, 32'd1);
    chk("held_symcnt", {29'd0, sym_count}, 32'd0);
    exp_letter("-");
    exp_space();
    hold(1'b0, 40);

    for (int n = 0; n < 40; n++) begin
      p = rand_pattern();
      exp_letter(p);
      if ($urandom_range(0, 3) == 0) begin
        exp_space();
        send(p, 40);
      end else begin
        send(p, $urandom_range(14, 22));
      end
    end
    exp_space();
    hold(1'b0, 40);

    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    chk("drain", q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
